// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter with ownership lock in front of a byte-column data memory.
// Build option DMEM_ARB_PERF_EN adds conflict and forced-lock-release counters.
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req0,
    input  logic                  i_req1,
    input  logic                  i_we0,
    input  logic                  i_we1,
    input  logic                  i_lock0,
    input  logic                  i_lock1,
    input  logic [ADDR_W-1:0]     i_addr0,
    input  logic [ADDR_W-1:0]     i_addr1,
    input  logic [DATA_W-1:0]     i_wdata0,
    input  logic [DATA_W-1:0]     i_wdata1,
    input  logic [DATA_W/8-1:0]   i_bmask0,
    input  logic [DATA_W/8-1:0]   i_bmask1,
    output logic                  o_gnt0,
    output logic                  o_gnt1,
    output logic                  o_rvalid0,
    output logic                  o_rvalid1,
    output logic [DATA_W-1:0]     o_rdata0,
    output logic [DATA_W-1:0]     o_rdata1,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_W-3:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_bmask,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]           o_perf_conflict,
    output logic [15:0]           o_perf_lockbrk,
`endif
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    logic          rr_ptr;
    logic [CW-1:0] lock_cnt;
    logic          gnt0;
    logic          gnt1;
    logic          unlock;
    logic          force_rel;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^{i_addr0[1:0], i_addr1[1:0]};

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        unique case (state)
            IDLE: begin
                gnt0 = i_req0 & (~i_req1 | ~rr_ptr);
                gnt1 = i_req1 & (~i_req0 | rr_ptr);
            end
            OWN0:    gnt0 = i_req0;
            OWN1:    gnt1 = i_req1;
            default: ;
        endcase
        if (i_reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    assign o_gnt0 = gnt0;
    assign o_gnt1 = gnt1;

    always_comb begin
        o_mem_en    = gnt0 | gnt1;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        if (gnt0) begin
            o_mem_we    = i_we0;
            o_mem_addr  = i_addr0[ADDR_W-1:2];
            o_mem_wdata = i_wdata0;
            o_mem_bmask = i_we0 ? i_bmask0 : '0;
        end else if (gnt1) begin
            o_mem_we    = i_we1;
            o_mem_addr  = i_addr1[ADDR_W-1:2];
            o_mem_wdata = i_wdata1;
            o_mem_bmask = i_we1 ? i_bmask1 : '0;
        end
    end

    assign o_rdata0 = o_rvalid0 ? i_mem_rdata : '0;
    assign o_rdata1 = o_rvalid1 ? i_mem_rdata : '0;

    // An owner's own unlocking access wins over the timeout release.
    assign unlock    = (state == OWN0 && gnt0 && !i_lock0)
                     || (state == OWN1 && gnt1 && !i_lock1);
    assign force_rel = (state != IDLE) && (lock_cnt == CW'(LOCK_MAX)) && !unlock;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            lock_cnt  <= '0;
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
        end else begin
            o_rvalid0 <= gnt0 & ~i_we0;
            o_rvalid1 <= gnt1 & ~i_we1;
            if (state == IDLE) begin
                lock_cnt <= '0;
                if (gnt0 || gnt1)
                    rr_ptr <= gnt0;
                if (gnt0 && i_lock0)
                    state <= OWN0;
                else if (gnt1 && i_lock1)
                    state <= OWN1;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
                if (unlock) begin
                    state <= IDLE;
                end else if (force_rel) begin
                    state  <= IDLE;
                    rr_ptr <= (state == OWN0);
                end
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_perf_conflict <= '0;
            o_perf_lockbrk  <= '0;
        end else begin
            if (i_req0 && i_req1 && o_perf_conflict != 16'hFFFF)
                o_perf_conflict <= o_perf_conflict + 16'd1;
            if (force_rel && o_perf_lockbrk != 16'hFFFF)
                o_perf_lockbrk <= o_perf_lockbrk + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory block between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader).
- The data memory is byte-column organised: 4 columns, one byte lane each, with synchronous 1-cycle read.
- Sits between the requesters and the memory macro.
- Provides round-robin arbitration, an ownership lock for read-modify-write sequences, and per-port read-data return.

Parameters:
- ADDR_W, 16: byte-address width of both requester ports.
- DATA_W, 32: data width; fixed at 4 byte lanes.
- LOCK_MAX, 15: maximum consecutive cycles one port may hold the lock before it is force-released.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_req0 / i_req1  in  1  access request, port 0 / port 1
- i_we0 / i_we1  in  1  1 = write, 0 = read
- i_lock0 / i_lock1  in  1  keep ownership after this access
- i_addr0 / i_addr1  in  ADDR_W  byte address
- i_wdata0 / i_wdata1  in  32  write data
- i_bmask0 / i_bmask1  in  4  byte-lane enables, bit n = column n
- o_gnt0 / o_gnt1  out  1  access accepted this cycle
- o_rvalid0 / o_rvalid1  out  1  read data valid
- o_rdata0 / o_rdata1  out  32  read data
- o_mem_en  out  1  memory access strobe
- o_mem_we  out  1  memory write
- o_mem_addr  out  ADDR_W-2  word address
- o_mem_wdata  out  32  write data to memory
- o_mem_bmask  out  4  byte-column write enables
- i_mem_rdata  in  32  memory read data, valid 1 cycle after o_mem_en with o_mem_we = 0

Behaviour:
- Clock and reset:
  - One clock, i_clk.
  - i_reset is asynchronous and active-high.
  - While i_reset is high: all outputs 0; FSM in IDLE; round-robin pointer = port 0; lock counter = 0.
- Grant is combinational in the request cycle:
  - o_gnt and o_mem_* are driven in the same cycle as the winning request.
  - A request must hold its signals stable until granted.
  - At most one grant per cycle.
  - Memory signals are a mux of the winner's signals: o_mem_addr = i_addrN[ADDR_W-1:2].
  - o_mem_bmask = i_bmaskN when writing; 4'b0000 on reads.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - Single request: that port wins.
  - Both request: the port indicated by the round-robin pointer wins.
  - After any grant in IDLE, the pointer moves to the other port.
  - Granted with i_lockN = 1 -> go to OWNN and clear the lock counter.
- OWNN:
  - Only port N can be granted. The other port's request waits; its o_gnt stays 0.
  - Lock counter increments every cycle.
  - Granted with i_lockN = 0 -> IDLE (the unlocking access itself is performed).
  - Cycle with no request from port N -> stay in OWNN.
  - Lock counter reaches LOCK_MAX -> force IDLE on the next edge; the pointer points to the other port.
- Read return:
  - o_rvalidN is a registered copy of (o_gntN & ~i_weN), 1-cycle latency.
  - o_rdataN = i_mem_rdata while o_rvalidN = 1; 0 otherwise.
  - Back-to-back reads give one rvalid per cycle.
- Write then read to the same address on consecutive cycles returns the new data (memory is write-first; no forwarding here).
- i_reset asserted mid-access: pending rvalid is dropped, and the lock is released.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds two 16-bit saturating counters: conflict cycles (both requesting, one stalled) and forced lock releases.
  - Counters are exposed as o_perf_conflict [15:0] and o_perf_lockbrk [15:0].
  - Both are cleared by i_reset and saturate at 16'hFFFF.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then port 0 reads address 16'h0010 with memory returning 32'hDEADBEEF:
  - o_gnt0 = 1 in the same cycle, with o_mem_addr = 14'h0004 and o_mem_bmask = 0.
  - o_rvalid0 = 1 and o_rdata0 = 32'hDEADBEEF next cycle.
- Both ports request continuously for 6 cycles from reset:
  - Grants alternate 0,1,0,1,0,1.
  - Each port gets exactly 3 grants.
- Port 1 writes 32'h12345678 to 16'h0020 with bmask 4'b0011:
  - o_mem_we = 1, o_mem_bmask = 4'b0011, o_mem_wdata = 32'h12345678.
  - No rvalid follows.
- Port 1 does a locked read, then an unlocked write, while port 0 requests throughout:
  - o_gnt0 stays 0 until port 1's write is granted.
  - Port 0 is granted the following cycle.
- Port 0 holds i_lock0 = 1 with continuous requests for 20 cycles while port 1 waits:
  - Forced release after LOCK_MAX = 15 cycles.
  - Port 1 is granted the next cycle.
  - With DMEM_ARB_PERF_EN: o_perf_lockbrk = 1.
- i_reset pulsed asynchronously one cycle after a read grant:
  - o_rvalid0 stays 0 and the FSM returns to IDLE.
  - The next simultaneous request is granted to port 0.
